// File: rtl/snoop_dispatch_arbiter.sv
// Round-robin dispatcher that locks the snooper write port onto one ready bpfvm per packet
// and steers write strobes and the end-of-packet pulse to that VM only.
module snoop_dispatch_arbiter #(
    parameter int unsigned N_VMS      = 4,
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned DATA_WIDTH = 64,
    localparam int unsigned SEL_W     = $clog2(N_VMS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] snooper_wr_addr,
    input  logic [DATA_WIDTH-1:0] snooper_wr_data,
    input  logic                  snooper_wr_en,
    input  logic                  snooper_done,
    output logic                  ready_for_snooper,
    input  logic [N_VMS-1:0]      vm_ready,
    output logic [ADDR_WIDTH-1:0] vm_wr_addr,
    output logic [DATA_WIDTH-1:0] vm_wr_data,
    output logic [N_VMS-1:0]      vm_wr_en,
    output logic [N_VMS-1:0]      vm_done,
    output logic [SEL_W-1:0]      grant_idx,
    output logic [31:0]           packets_dispatched,
    output logic [15:0]           dropped_writes
);

    typedef enum logic [1:0] {StIdle, StLocked, StRelease} state_e;

    state_e           state;
    logic [SEL_W-1:0] rr_ptr;
    logic             ready;
    logic [SEL_W-1:0] grant;
    logic [31:0]      pkt_cnt;
    logic [15:0]      drop_cnt;

    logic             pick_found;
    logic [SEL_W-1:0] pick_idx;
    logic [SEL_W-1:0] cand;
    logic [SEL_W-1:0] grant_next;

    // First ready VM at or after rr_ptr, wrapping modulo N_VMS.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int unsigned i = 0; i < N_VMS; i++) begin
            cand = SEL_W'((32'(rr_ptr) + i) % N_VMS);
            if (!pick_found && vm_ready[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    assign grant_next = (grant == SEL_W'(N_VMS - 1)) ? '0 : grant + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= StIdle;
            ready    <= 1'b0;
            grant    <= '0;
            rr_ptr   <= '0;
            pkt_cnt  <= '0;
            drop_cnt <= '0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (pick_found) begin
                        grant <= pick_idx;
                        ready <= 1'b1;
                        state <= StLocked;
                    end
                end
                StLocked: begin
                    if (snooper_done) begin
                        rr_ptr  <= grant_next;
                        pkt_cnt <= pkt_cnt + 32'd1;
                        ready   <= 1'b0;
                        state   <= StRelease;
                    end
                end
                // One dead cycle so the just-released VM's stale ready is not re-arbitrated.
                StRelease: state <= StIdle;
                default:   state <= StIdle;
            endcase
            if (state != StLocked && (snooper_wr_en || snooper_done) && drop_cnt != 16'hFFFF) begin
                drop_cnt <= drop_cnt + 16'd1;
            end
        end
    end

    always_comb begin
        vm_wr_en = '0;
        vm_done  = '0;
        if (state == StLocked) begin
            vm_wr_en[grant] = snooper_wr_en;
            vm_done[grant]  = snooper_done;
        end
    end

    assign vm_wr_addr         = snooper_wr_addr;
    assign vm_wr_data         = snooper_wr_data;
    assign ready_for_snooper  = ready;
    assign grant_idx          = grant;
    assign packets_dispatched = pkt_cnt;
    assign dropped_writes     = drop_cnt;

endmodule

// File: tb/tb_snoop_dispatch_arbiter.sv
// Cycle-by-cycle vector table for snoop_dispatch_arbiter with a scoreboard queue of expectations,
// plus hand-written saturation and mid-packet reset sequences.
module tb_snoop_dispatch_arbiter;

    localparam int unsigned N  = 4;
    localparam int unsigned AW = 10;
    localparam int unsigned DW = 64;

    typedef struct {
        logic        rst;
        logic [3:0]  rdy;
        logic        wr;
        logic        dn;
        logic        e_ready;
        logic [3:0]  e_wr;
        logic [3:0]  e_done;
        logic [1:0]  e_grant;
        logic [31:0] e_pkts;
        logic [15:0] e_drop;
    } vec_t;

    typedef struct {
        vec_t          v;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] snooper_wr_addr;
    logic [DW-1:0] snooper_wr_data;
    logic          snooper_wr_en;
    logic          snooper_done;
    logic          ready_for_snooper;
    logic [N-1:0]  vm_ready;
    logic [AW-1:0] vm_wr_addr;
    logic [DW-1:0] vm_wr_data;
    logic [N-1:0]  vm_wr_en;
    logic [N-1:0]  vm_done;
    logic [1:0]    grant_idx;
    logic [31:0]   packets_dispatched;
    logic [15:0]   dropped_writes;

    int   n_cmp  = 0;
    int   n_fail = 0;
    int   row_no = 0;
    vec_t tbl[$];
    exp_t sb[$];

    always #5 clk = ~clk;

    snoop_dispatch_arbiter #(
        .N_VMS     (N),
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .snooper_wr_addr   (snooper_wr_addr),
        .snooper_wr_data   (snooper_wr_data),
        .snooper_wr_en     (snooper_wr_en),
        .snooper_done      (snooper_done),
        .ready_for_snooper (ready_for_snooper),
        .vm_ready          (vm_ready),
        .vm_wr_addr        (vm_wr_addr),
        .vm_wr_data        (vm_wr_data),
        .vm_wr_en          (vm_wr_en),
        .vm_done           (vm_done),
        .grant_idx         (grant_idx),
        .packets_dispatched(packets_dispatched),
        .dropped_writes    (dropped_writes)
    );

    function automatic vec_t mk(logic r, logic [3:0] rdy, logic wr, logic dn, logic er,
                                logic [3:0] ewr, logic [3:0] edn, logic [1:0] eg,
                                logic [31:0] ep, logic [15:0] ed);
        vec_t v;
        v.rst = r;   v.rdy = rdy;   v.wr = wr;       v.dn = dn;
        v.e_ready = er; v.e_wr = ewr; v.e_done = edn; v.e_grant = eg;
        v.e_pkts = ep;  v.e_drop = ed;
        return v;
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL row %0d %s: got %0h, expected %0h", row_no, name, act, exp);
        end
    endtask

    // Drive one cycle just after the edge, queue its expectation, check at the falling edge.
    task automatic apply(vec_t v);
        exp_t e;
        @(posedge clk);
        #1;
        rst             = v.rst;
        vm_ready        = v.rdy;
        snooper_wr_en   = v.wr;
        snooper_done    = v.dn;
        snooper_wr_addr = AW'($urandom);
        snooper_wr_data = {$urandom, $urandom};
        e.v    = v;
        e.addr = snooper_wr_addr;
        e.data = snooper_wr_data;
        sb.push_back(e);
        @(negedge clk);
        e = sb.pop_front();
        chk("ready_for_snooper", 64'(ready_for_snooper), 64'(e.v.e_ready));
        chk("vm_wr_en", 64'(vm_wr_en), 64'(e.v.e_wr));
        chk("vm_done", 64'(vm_done), 64'(e.v.e_done));
        chk("grant_idx", 64'(grant_idx), 64'(e.v.e_grant));
        chk("packets_dispatched", 64'(packets_dispatched), 64'(e.v.e_pkts));
        chk("dropped_writes", 64'(dropped_writes), 64'(e.v.e_drop));
        chk("vm_wr_addr", 64'(vm_wr_addr), 64'(e.addr));
        chk("vm_wr_data", vm_wr_data, e.data);
        row_no++;
    endtask

    initial begin
        rst = 1'b1; vm_ready = '0; snooper_wr_en = 1'b0; snooper_done = 1'b0;
        snooper_wr_addr = '0; snooper_wr_data = '0;
        repeat (2) @(posedge clk);

        //                rst rdy    wr dn   rdy ewr   edn   g  pkts drop
        // First packet on VM0: three writes then done.
        tbl.push_back(mk(0, 4'hF, 0, 0,  0, 4'h0, 4'h0, 0, 0, 0));
        tbl.push_back(mk(0, 4'hF, 1, 0,  1, 4'h1, 4'h0, 0, 0, 0));
        tbl.push_back(mk(0, 4'hF, 1, 0,  1, 4'h1, 4'h0, 0, 0, 0));
        tbl.push_back(mk(0, 4'hF, 1, 0,  1, 4'h1, 4'h0, 0, 0, 0));
        tbl.push_back(mk(0, 4'hF, 0, 1,  1, 4'h0, 4'h1, 0, 0, 0));
        // Round robin 1,2,3,0 with two low-ready cycles after each done.
        tbl.push_back(mk(0, 4'hF, 0, 0,  0, 4'h0, 4'h0, 0, 1, 0));
        tbl.push_back(mk(0, 4'hF, 0, 0,  0, 4'h0, 4'h0, 0, 1, 0));
        tbl.push_back(mk(0, 4'hF, 0, 1,  1, 4'h0, 4'h2, 1, 1, 0));
        tbl.push_back(mk(0, 4'hF, 0, 0,  0, 4'h0, 4'h0, 1, 2, 0));
        tbl.push_back(mk(0, 4'hF, 0, 0,  0, 4'h0, 4'h0, 1, 2, 0));
        tbl.push_back(mk(0, 4'hF, 0, 1,  1, 4'h0, 4'h4, 2, 2, 0));
        tbl.push_back(mk(0, 4'hF, 0, 0,  0, 4'h0, 4'h0, 2, 3, 0));
        tbl.push_back(mk(0, 4'hF, 0, 0,  0, 4'h0, 4'h0, 2, 3, 0));
        tbl.push_back(mk(0, 4'hF, 0, 1,  1, 4'h0, 4'h8, 3, 3, 0));
        tbl.push_back(mk(0, 4'hF, 0, 0,  0, 4'h0, 4'h0, 3, 4, 0));
        tbl.push_back(mk(0, 4'hF, 0, 0,  0, 4'h0, 4'h0, 3, 4, 0));
        tbl.push_back(mk(0, 4'hF, 0, 1,  1, 4'h0, 4'h1, 0, 4, 0));
        tbl.push_back(mk(0, 4'hF, 0, 0,  0, 4'h0, 4'h0, 0, 5, 0));
        // Packet on VM1, then ready=0011 with rr_ptr=2 must wrap to VM0.
        tbl.push_back(mk(0, 4'h2, 0, 0,  0, 4'h0, 4'h0, 0, 5, 0));
        tbl.push_back(mk(0, 4'h3, 0, 1,  1, 4'h0, 4'h2, 1, 5, 0));
        tbl.push_back(mk(0, 4'h3, 0, 0,  0, 4'h0, 4'h0, 1, 6, 0));
        tbl.push_back(mk(0, 4'h3, 0, 0,  0, 4'h0, 4'h0, 1, 6, 0));
        // Granted VM's ready drops while locked: grant held.
        tbl.push_back(mk(0, 4'h0, 1, 0,  1, 4'h1, 4'h0, 0, 6, 0));
        tbl.push_back(mk(0, 4'h0, 0, 1,  1, 4'h0, 4'h1, 0, 6, 0));
        tbl.push_back(mk(0, 4'h0, 0, 0,  0, 4'h0, 4'h0, 0, 7, 0));
        // Strobes with no grant are dropped and counted.
        tbl.push_back(mk(0, 4'h0, 1, 0,  0, 4'h0, 4'h0, 0, 7, 0));
        tbl.push_back(mk(0, 4'h0, 1, 0,  0, 4'h0, 4'h0, 0, 7, 1));
        tbl.push_back(mk(0, 4'h0, 0, 1,  0, 4'h0, 4'h0, 0, 7, 2));
        // VM2 gets write and done in the same cycle; write during RELEASE is dropped.
        tbl.push_back(mk(0, 4'h4, 0, 0,  0, 4'h0, 4'h0, 0, 7, 3));
        tbl.push_back(mk(0, 4'h4, 1, 1,  1, 4'h4, 4'h4, 2, 7, 3));
        tbl.push_back(mk(0, 4'h0, 1, 0,  0, 4'h0, 4'h0, 2, 8, 3));
        tbl.push_back(mk(0, 4'h0, 0, 0,  0, 4'h0, 4'h0, 2, 8, 4));

        foreach (tbl[i]) apply(tbl[i]);

        // Saturation of the drop counter.
        for (int i = 0; i < 70000; i++) begin
            @(posedge clk);
            #1;
            vm_ready      = '0;
            snooper_wr_en = 1'b1;
            snooper_done  = 1'b0;
        end
        apply(mk(0, 4'h0, 1, 0,  0, 4'h0, 4'h0, 2, 8, 16'hFFFF));
        apply(mk(0, 4'h0, 0, 0,  0, 4'h0, 4'h0, 2, 8, 16'hFFFF));

        // Reset mid-packet on VM1: no done, counters cleared, rearbitrates from 0.
        apply(mk(0, 4'h2, 0, 0,  0, 4'h0, 4'h0, 2, 8, 16'hFFFF));
        apply(mk(0, 4'h0, 1, 0,  1, 4'h2, 4'h0, 1, 8, 16'hFFFF));
        apply(mk(1, 4'h2, 1, 0,  1, 4'h2, 4'h0, 1, 8, 16'hFFFF));
        apply(mk(0, 4'h2, 0, 0,  0, 4'h0, 4'h0, 0, 0, 0));
        apply(mk(0, 4'h2, 0, 0,  1, 4'h0, 4'h0, 1, 0, 0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
